uart_transmitter: RTL
=====================

# uart_transmitter

Serial UART transmitter, the transmit-side counterpart of the keyboard UART receiver. Accepts bytes from the processor's I/O path over a valid/ready handshake, buffers them in a small FIFO, and shifts each out on `uart_out` as an 8N1 frame: one start bit, 8 data bits LSB first, one stop bit. Lets the FemtoRV32 datapath echo keys or print results to the host terminal at the same baud rate the receiver uses.

## Interface
- `CLKS_PER_BIT`, 10417, clock cycles per serial bit (100 MHz / 9600 baud); legal ≥ 2
- `FIFO_DEPTH`, 4, byte buffer depth; power of two, ≥ 2
- `clk` input 1, system clock, all logic on rising edge
- `rst_n` input 1, asynchronous active-low reset
- `tx_data` input 8, byte to send
- `tx_valid` input 1, producer offers `tx_data` this cycle
- `tx_ready` output 1, FIFO can accept a byte (`!full`)
- `uart_out` output 1, serial line, idle high
- `busy` output 1, frame in progress or FIFO non-empty
- `fifo_count` output $clog2(FIFO_DEPTH)+1, bytes currently buffered

## Operation
- Push: byte written to FIFO on any edge where `tx_valid && tx_ready`. When `tx_ready` is low, `tx_data` is ignored; the producer must hold `tx_valid`/`tx_data` until accepted.
- `tx_ready = (fifo_count != FIFO_DEPTH)`. It is combinational from registered count, so a same-cycle pop does not enable a push when full.
- Pop: FSM removes the head byte into an internal shift register when leaving IDLE or the last STOP cycle with FIFO non-empty.
- Simultaneous push and pop: both take effect and `fifo_count` is unchanged. Pointers wrap modulo `FIFO_DEPTH`.
- FSM states:
  - IDLE: `uart_out`=1. If FIFO non-empty: pop, go to START.
  - START: `uart_out`=0 for `CLKS_PER_BIT` cycles, then go to DATA with bit index 0.
  - DATA: `uart_out`=shift[0] for `CLKS_PER_BIT` cycles per bit. Shift right after each bit. After bit 7, go to STOP.
  - STOP: `uart_out`=1 for `CLKS_PER_BIT` cycles. On the last cycle: if FIFO non-empty, pop and go to START (back-to-back frames, no extra idle bit); else go to IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT`-1, resets to 0 on every bit/state change.
- `uart_out` is a registered output, so there are no glitches on the line.
- `busy = (state != IDLE) || (fifo_count != 0)`.
- Reset (any time, including mid-frame): state IDLE, FIFO emptied, counters 0, `uart_out`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0. A partial frame is abandoned, not completed.

## Timing
- Push accepted at edge k with FSM in IDLE and FIFO empty: `fifo_count`=1 after k. Pop occurs and `uart_out` goes low after edge k+1, so the line falls 1 cycle after acceptance.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles from the start-bit falling edge to the end of the stop bit.
- Back-to-back: the next start bit begins on the cycle immediately after the final stop-bit cycle.
- `busy` falls on the cycle `uart_out` has completed the last stop bit with the FIFO empty.
- Throughput: one byte per 10×`CLKS_PER_BIT` cycles. The producer sees `tx_ready` low once `FIFO_DEPTH` bytes are queued. During a frame the shift register holds one extra byte, so capacity is `FIFO_DEPTH`+1 bytes.

## Test plan
(Bench uses `CLKS_PER_BIT`=4, `FIFO_DEPTH`=4.)
- Reset: assert `rst_n`=0 → `uart_out`=1, `tx_ready`=1, `busy`=0, `fifo_count`=0. Release reset; with no `tx_valid`, the line stays 1 for 100 cycles.
- Single byte 0xA5, pushed at edge k: `uart_out` low from k+1 for 4 cycles. Then 1,0,1,0,0,1,0,1 at 4 cycles each, then stop=1 for 4 cycles. `busy` is low at cycle k+41. The reference UART receiver model decodes 0xA5.
- Burst of 0x01,0x02,0x03,0x04,0x05,0x06 pushed on consecutive cycles: `tx_ready` drops after 5 accepted bytes (one popped, 4 queued). Remaining bytes are accepted as frames complete. The line shows 6 contiguous 40-cycle frames with no idle gap, decoded in order.
- Hold `tx_valid`=1 while full, then a pop occurs at the end of the first frame: the held byte is accepted on the edge after `tx_ready` rises. No byte is lost or duplicated.
- Reset mid-frame: assert `rst_n`=0 during data bit 3 of 0x00 with 2 bytes queued → `uart_out`=1 immediately, `fifo_count`=0. After release the line stays idle and no residual frame is sent.
- Edge data 0x00 and 0xFF: the line is low for 9 bit-times or the start bit plus 8 high bits respectively, and the stop bit is always high.

Source files
------------

// File: rtl/uart_transmitter.sv
// uart_transmitter: byte FIFO feeding an 8N1 serial shifter.
// Bytes arrive over a tx_valid/tx_ready handshake, wait in a small FIFO and
// leave on uart_out as start bit, 8 data bits LSB first, then stop bit.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 10417,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [1:0]                    fsm_state
);

    // Handshake: a byte is taken on every rising edge where tx_valid && tx_ready.
    // The producer holds tx_valid and tx_data stable until that edge; tx_ready
    // depends only on the registered count, never on tx_valid.

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic             line_n;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             push, pop, fifo_empty, bit_done;

    assign tx_ready   = (fifo_count != FULL_COUNT);
    assign push       = tx_valid && tx_ready;
    assign fifo_empty = (fifo_count == '0);
    assign bit_done   = (baud_cnt == LAST_CNT);
    assign busy       = (state != IDLE) || !fifo_empty;
    assign fsm_state  = state;

    // FIFO storage; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (depth is a power of two).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Frame state, baud timing, shifter and the registered serial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            uart_out <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_idx  <= bit_idx_n;
            shift    <= shift_n;
            uart_out <= line_n;
        end
    end

    // Next-state logic; the line level is derived from the next state so the
    // registered uart_out changes on the same edge as the state does.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_idx_n  = bit_idx;
        shift_n    = shift;
        pop        = 1'b0;
        line_n     = 1'b1;

        case (state)
            IDLE: begin
                baud_cnt_n = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    state_n = START;
                end
            end
            START: begin
                if (bit_done) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    state_n    = DATA;
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_cnt_n = '0;
                    shift_n    = shift >> 1;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    baud_cnt_n = '0;
                    if (!fifo_empty) begin
                        // Back-to-back frame: no idle bit between stop and start.
                        pop     = 1'b1;
                        shift_n = mem[rd_ptr];
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        case (state_n)
            START:   line_n = 1'b0;
            DATA:    line_n = shift_n[0];
            default: line_n = 1'b1;
        endcase
    end

endmodule
